// File: rtl/arm_rf_pkg.sv
// Shared definitions for the ARM banked register file: mode encodings,
// physical register count and the architectural-to-physical mapping.
package arm_rf_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int NPHYS = 31;

  // True for the seven architecturally defined CPSR mode values.
  function automatic logic mode_legal(input logic [4:0] mode);
    case (mode)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: mode_legal = 1'b1;
      default:                      mode_legal = 1'b0;
    endcase
  endfunction

  // Physical index for an architectural register in a given mode.
  // SYS and any illegal mode fall through to the USR bank (index = addr).
  function automatic logic [4:0] phys_idx(input logic [4:0] mode,
                                          input logic [3:0] addr);
    logic [4:0] idx;
    idx = {1'b0, addr};
    case (mode)
      MODE_FIQ: if (addr >= 4'd8 && addr <= 4'd14) idx = {1'b0, addr} + 5'd8;
      MODE_IRQ: if (addr == 4'd13) idx = 5'd23; else if (addr == 4'd14) idx = 5'd24;
      MODE_SVC: if (addr == 4'd13) idx = 5'd25; else if (addr == 4'd14) idx = 5'd26;
      MODE_ABT: if (addr == 4'd13) idx = 5'd27; else if (addr == 4'd14) idx = 5'd28;
      MODE_UND: if (addr == 4'd13) idx = 5'd29; else if (addr == 4'd14) idx = 5'd30;
      default:  idx = {1'b0, addr};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/arm_rf_read_port.sv
// One registered read port: maps the address through the effective mode,
// optionally forwards the value being written on the same edge, and latches
// the result on the falling clock edge when its load enable is set.
module arm_rf_read_port
  import arm_rf_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic [4:0]      eff_mode,
  input  logic            lr,
  input  logic [3:0]      r_addr,
  input  logic [SIZE-1:0] regs [NPHYS],
  input  logic            wr_en,
  input  logic [4:0]      wr_phys,
  input  logic [SIZE-1:0] w_data,
  input  logic            pc_inc_en,
  input  logic [SIZE-1:0] pc_next,
  output logic [SIZE-1:0] r_data
);

  logic [4:0]      rd_phys;
  logic [SIZE-1:0] r_data_d;
  logic [SIZE-1:0] r_data_q;

  // Select the value to capture: forwarded write data, forwarded PC increment,
  // or the stored value; hold when the port is not enabled.
  always_comb begin
    rd_phys  = phys_idx(eff_mode, r_addr);
    r_data_d = r_data_q;
    if (lr) begin
      if ((BYPASS != 0) && wr_en && (wr_phys == rd_phys))
        r_data_d = w_data;
      else if ((BYPASS != 0) && pc_inc_en && (rd_phys == 5'd15))
        r_data_d = pc_next;
      else
        r_data_d = regs[rd_phys];
    end
  end

  // Read latch, falling-edge clocked with asynchronous clear.
  always_ff @(negedge clk or posedge Rst) begin
    if (Rst) r_data_q <= '0;
    else     r_data_q <= r_data_d;
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/arm_banked_regfile.sv
// ARM banked register file: 31 physical registers presented as 16
// architectural registers per processor mode, one write port, NRD registered
// read ports, PC auto-increment and an illegal-mode flag.
module arm_banked_regfile
  import arm_rf_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int NRD     = 3,
  parameter int PC_STEP = 4,
  parameter int BYPASS  = 1
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic [4:0]          Mode,
  input  logic                User_Bank,
  input  logic                Write_Reg,
  input  logic [3:0]          W_Addr,
  input  logic [SIZE-1:0]     W_Data,
  input  logic                PC_Inc,
  input  logic [NRD-1:0]      LR,
  input  logic [4*NRD-1:0]    R_Addr,
  output logic [SIZE*NRD-1:0] R_Data,
  output logic [SIZE-1:0]     PC_Out,
  output logic                Mode_Err
);

  localparam logic [SIZE-1:0] PC_STEP_V = SIZE'(PC_STEP);

  logic [SIZE-1:0] regs_q [NPHYS];
  logic [SIZE-1:0] regs_d [NPHYS];
  logic            mode_err_q;
  logic            mode_err_d;
  logic [4:0]      eff_mode;
  logic [4:0]      w_phys;
  logic            pc_inc_en;
  logic [SIZE-1:0] pc_next;

  // Effective bank, write target and PC update; an explicit R15 write beats PC_Inc.
  always_comb begin
    eff_mode   = User_Bank ? MODE_USR : Mode;
    w_phys     = phys_idx(eff_mode, W_Addr);
    pc_inc_en  = PC_Inc && !(Write_Reg && (W_Addr == 4'd15));
    pc_next    = regs_q[15] + PC_STEP_V;
    mode_err_d = !mode_legal(Mode);
    regs_d     = regs_q;
    if (pc_inc_en) regs_d[15] = pc_next;
    if (Write_Reg) regs_d[w_phys] = W_Data;
  end

  // Register storage and error flag, falling-edge clocked with asynchronous clear.
  always_ff @(negedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
      mode_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      mode_err_q <= mode_err_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    arm_rf_read_port #(
      .SIZE   (SIZE),
      .BYPASS (BYPASS)
    ) u_port (
      .clk       (clk),
      .Rst       (Rst),
      .eff_mode  (eff_mode),
      .lr        (LR[k]),
      .r_addr    (R_Addr[4*k +: 4]),
      .regs      (regs_q),
      .wr_en     (Write_Reg),
      .wr_phys   (w_phys),
      .w_data    (W_Data),
      .pc_inc_en (pc_inc_en),
      .pc_next   (pc_next),
      .r_data    (R_Data[SIZE*k +: SIZE])
    );
  end

  assign PC_Out   = regs_q[15];
  assign Mode_Err = mode_err_q;

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Directed bench for arm_banked_regfile: one bypassing and one non-bypassing
// instance share all inputs; expected values are hand-computed constants.
module tb_arm_banked_regfile;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_SYS = 5'b11111;

  logic        clk = 1'b1;
  logic        Rst;
  logic [4:0]  Mode;
  logic        User_Bank;
  logic        Write_Reg;
  logic [3:0]  W_Addr;
  logic [31:0] W_Data;
  logic        PC_Inc;
  logic [2:0]  LR;
  logic [11:0] R_Addr;
  logic [95:0] rd_b, rd_n;
  logic [31:0] pc_b, pc_n;
  logic        err_b, err_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arm_banked_regfile #(.SIZE(32), .NRD(3), .PC_STEP(4), .BYPASS(1)) dut_b (
    .clk(clk), .Rst(Rst), .Mode(Mode), .User_Bank(User_Bank),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .PC_Inc(PC_Inc),
    .LR(LR), .R_Addr(R_Addr), .R_Data(rd_b), .PC_Out(pc_b), .Mode_Err(err_b));

  arm_banked_regfile #(.SIZE(32), .NRD(3), .PC_STEP(4), .BYPASS(0)) dut_n (
    .clk(clk), .Rst(Rst), .Mode(Mode), .User_Bank(User_Bank),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .PC_Inc(PC_Inc),
    .LR(LR), .R_Addr(R_Addr), .R_Data(rd_n), .PC_Out(pc_n), .Mode_Err(err_n));

  function automatic logic [31:0] port(input logic [95:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next active (falling) edge and settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    Write_Reg = 1'b1; W_Addr = a; W_Data = d;
  endtask

  initial begin
    Rst = 1'b1; Mode = M_USR; User_Bank = 1'b0; Write_Reg = 1'b0;
    W_Addr = 4'd0; W_Data = 32'h0; PC_Inc = 1'b0; LR = 3'b000; R_Addr = 12'h0;
    tick(); tick();
    Rst = 1'b0;

    // Load some state so the reset below has something to clear
    wr(4'd1, 32'h0000_1234); tick();
    wr(4'd15, 32'h0000_0040); LR = 3'b001; R_Addr = {4'd0, 4'd0, 4'd1}; tick();
    check("pre_rst_r1", port(rd_b, 0), 32'h0000_1234);
    check("pre_rst_pc", pc_b, 32'h0000_0040);

    // Mid-cycle reset with a write pending
    wr(4'd1, 32'h0000_9999);
    #2; Rst = 1'b1; #1;
    check("rst_p0", port(rd_b, 0), 32'h0);
    check("rst_p1", port(rd_b, 1), 32'h0);
    check("rst_p2", port(rd_b, 2), 32'h0);
    check("rst_pc", pc_b, 32'h0);
    check("rst_err", {31'h0, err_b}, 32'h0);
    tick();
    check("rst_hold_p0", port(rd_b, 0), 32'h0);
    Rst = 1'b0; Write_Reg = 1'b0; tick();
    check("rst_nowrite_r1", port(rd_b, 0), 32'h0);
    check("rst_nowrite_pc", pc_b, 32'h0);

    // R13 banking: USR vs IRQ vs SYS, all three ports on the same register
    Mode = M_USR; wr(4'd13, 32'h0000_1111); LR = 3'b000; tick();
    Mode = M_IRQ; wr(4'd13, 32'h0000_2222); tick();
    Write_Reg = 1'b0; LR = 3'b111; R_Addr = {4'd13, 4'd13, 4'd13};
    Mode = M_USR; tick();
    check("usr_r13_p0", port(rd_b, 0), 32'h0000_1111);
    check("usr_r13_p1", port(rd_b, 1), 32'h0000_1111);
    check("usr_r13_p2", port(rd_b, 2), 32'h0000_1111);
    Mode = M_IRQ; tick();
    check("irq_r13", port(rd_b, 0), 32'h0000_2222);
    Mode = M_SYS; tick();
    check("sys_r13", port(rd_b, 2), 32'h0000_1111);
    check("sys_err", {31'h0, err_b}, 32'h0);

    // FIQ R8 banking and the user-bank override
    LR = 3'b001; R_Addr = {4'd13, 4'd13, 4'd8};
    Mode = M_FIQ; wr(4'd8, 32'hAAAA_0008); tick();
    Write_Reg = 1'b0; Mode = M_SVC; tick();
    check("svc_r8", port(rd_b, 0), 32'h0);
    Mode = M_FIQ; User_Bank = 1'b1; tick();
    check("fiq_ub_r8", port(rd_b, 0), 32'h0);
    User_Bank = 1'b0; tick();
    check("fiq_r8", port(rd_b, 0), 32'hAAAA_0008);
    User_Bank = 1'b1; wr(4'd9, 32'h0000_0099); LR = 3'b000; tick();
    Write_Reg = 1'b0; User_Bank = 1'b0; LR = 3'b001; R_Addr = {4'd13, 4'd13, 4'd9};
    tick();
    check("fiq_r9", port(rd_b, 0), 32'h0);
    Mode = M_USR; tick();
    check("usr_r9_ub_write", port(rd_b, 0), 32'h0000_0099);

    // Write-to-read bypass on R5
    wr(4'd5, 32'h1234_5678); LR = 3'b000; tick();
    wr(4'd5, 32'hDEAD_BEEF); LR = 3'b001; R_Addr = {4'd13, 4'd13, 4'd5}; tick();
    check("byp1_r5", port(rd_b, 0), 32'hDEAD_BEEF);
    check("byp0_r5", port(rd_n, 0), 32'h1234_5678);
    Write_Reg = 1'b0; tick();
    check("byp0_r5_after", port(rd_n, 0), 32'hDEAD_BEEF);

    // PC wrap, increment bypass, and write beating PC_Inc
    wr(4'd15, 32'hFFFF_FFFC); LR = 3'b000; tick();
    check("pc_set", pc_b, 32'hFFFF_FFFC);
    Write_Reg = 1'b0; PC_Inc = 1'b1; LR = 3'b001; R_Addr = {4'd13, 4'd13, 4'd15}; tick();
    check("pc_wrap", pc_b, 32'h0);
    check("pc_wrap_n", pc_n, 32'h0);
    check("pc_byp1", port(rd_b, 0), 32'h0);
    check("pc_byp0", port(rd_n, 0), 32'hFFFF_FFFC);
    wr(4'd15, 32'h0000_0100); tick();
    check("pc_wr_wins", pc_b, 32'h0000_0100);
    check("pc_wr_byp", port(rd_b, 0), 32'h0000_0100);
    Write_Reg = 1'b0; tick();
    check("pc_inc", pc_b, 32'h0000_0104);
    PC_Inc = 1'b0; tick();
    check("pc_hold", pc_b, 32'h0000_0104);

    // Illegal mode maps as USR and raises Mode_Err; a legal mode clears it
    Mode = 5'b00000; wr(4'd13, 32'h0000_7777); R_Addr = {4'd13, 4'd13, 4'd13}; tick();
    check("bad_mode_err", {31'h0, err_b}, 32'h1);
    check("bad_mode_r13", port(rd_b, 0), 32'h0000_7777);
    Write_Reg = 1'b0; Mode = M_SVC; tick();
    check("svc_err_clr", {31'h0, err_b}, 32'h0);
    check("svc_r13", port(rd_b, 0), 32'h0);
    Mode = M_USR; tick();
    check("usr_r13_new", port(rd_b, 0), 32'h0000_7777);

    // Load enables low: outputs hold across writes to the addressed register
    LR = 3'b000; wr(4'd13, 32'h0000_BBBB); tick();
    check("hold_p0", port(rd_b, 0), 32'h0000_7777);
    wr(4'd2, 32'h0000_0002); tick();
    check("hold_p0_b", port(rd_b, 0), 32'h0000_7777);
    check("hold_p1", port(rd_b, 1), 32'h0000_1111);
    Write_Reg = 1'b0; LR = 3'b010; tick();
    check("p1_r13_final", port(rd_b, 1), 32'h0000_BBBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
